// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath (master) and the hazard controller (slave).
// The datapath supplies the ID-stage decode fields and branch resolution; the controller returns enables, forwarding selects and status.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       ID_rs1;
    logic [4:0]       ID_rs2;
    logic             ID_rs1_used;
    logic             ID_rs2_used;
    logic [4:0]       ID_rd;
    logic             ID_RF_Enable;
    logic             ID_Load_Instr;
    logic             EX_Branch_Taken;
    logic             PC_LE;
    logic             IF_ID_LE;
    logic             IF_ID_Flush;
    logic             ID_EX_Bubble;
    logic [1:0]       Fwd_A;
    logic [1:0]       Fwd_B;
    logic [1:0]       Ctrl_State;
    logic [CNT_W-1:0] Stall_Count;
    logic [CNT_W-1:0] Flush_Count;

    modport master (
        output ID_rs1, ID_rs2, ID_rs1_used, ID_rs2_used, ID_rd,
               ID_RF_Enable, ID_Load_Instr, EX_Branch_Taken,
        input  PC_LE, IF_ID_LE, IF_ID_Flush, ID_EX_Bubble,
               Fwd_A, Fwd_B, Ctrl_State, Stall_Count, Flush_Count
    );

    modport slave (
        input  ID_rs1, ID_rs2, ID_rs1_used, ID_rs2_used, ID_rd,
               ID_RF_Enable, ID_Load_Instr, EX_Branch_Taken,
        output PC_LE, IF_ID_LE, IF_ID_Flush, ID_EX_Bubble,
               Fwd_A, Fwd_B, Ctrl_State, Stall_Count, Flush_Count
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a 5-stage RISC-V pipeline: shadow rd scoreboard for EX/MEM/WB,
// operand forwarding selects, load-use stall / branch flush actions and saturating event counters.
module pipeline_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input logic                  clk,
    input logic                  Reset,
    pipeline_hazard_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_FLUSH = 2'b10
    } state_t;

    // Only the EX entry needs the load flag: a load past EX is resolved by forwarding alone.
    logic [4:0]       ex_rd, mem_rd, wb_rd;
    logic             ex_wr, mem_wr, wb_wr;
    logic             ex_ld;
    state_t           state;
    state_t           action;
    logic             load_use;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;

    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic       used,
        input logic [4:0] e_rd, input logic e_wr,
        input logic [4:0] m_rd, input logic m_wr,
        input logic [4:0] w_rd, input logic w_wr
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (used && rs != 5'd0) begin
            if (e_wr && e_rd == rs)
                sel = 2'b01;
            else if (m_wr && m_rd == rs)
                sel = 2'b10;
            else if (w_wr && w_rd == rs)
                sel = 2'b11;
        end
        return sel;
    endfunction

    always_comb begin
        fwd_a = fwd_sel(bus.ID_rs1, bus.ID_rs1_used, ex_rd, ex_wr, mem_rd, mem_wr, wb_rd, wb_wr);
        fwd_b = fwd_sel(bus.ID_rs2, bus.ID_rs2_used, ex_rd, ex_wr, mem_rd, mem_wr, wb_rd, wb_wr);

        load_use = ex_ld && ex_wr &&
                   ((bus.ID_rs1_used && bus.ID_rs1 != 5'd0 && bus.ID_rs1 == ex_rd) ||
                    (bus.ID_rs2_used && bus.ID_rs2 != 5'd0 && bus.ID_rs2 == ex_rd));

        // A taken branch squashes the ID instruction, so its load-use hazard is moot.
        if (bus.EX_Branch_Taken)
            action = ST_FLUSH;
        else if (load_use)
            action = ST_STALL;
        else
            action = ST_RUN;
    end

    always_comb begin
        bus.PC_LE        = 1'b1;
        bus.IF_ID_LE     = 1'b1;
        bus.IF_ID_Flush  = 1'b0;
        bus.ID_EX_Bubble = 1'b0;
        bus.Fwd_A        = fwd_a;
        bus.Fwd_B        = fwd_b;
        unique case (action)
            ST_FLUSH: begin
                bus.IF_ID_Flush  = 1'b1;
                bus.ID_EX_Bubble = 1'b1;
            end
            ST_STALL: begin
                bus.PC_LE        = 1'b0;
                bus.IF_ID_LE     = 1'b0;
                bus.ID_EX_Bubble = 1'b1;
            end
            default: ;
        endcase
        // Hold the front end frozen and squashed while in reset.
        if (Reset) begin
            bus.PC_LE        = 1'b0;
            bus.IF_ID_LE     = 1'b0;
            bus.IF_ID_Flush  = 1'b1;
            bus.ID_EX_Bubble = 1'b1;
            bus.Fwd_A        = 2'b00;
            bus.Fwd_B        = 2'b00;
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            ex_rd     <= 5'd0;
            ex_wr     <= 1'b0;
            ex_ld     <= 1'b0;
            mem_rd    <= 5'd0;
            mem_wr    <= 1'b0;
            wb_rd     <= 5'd0;
            wb_wr     <= 1'b0;
            state     <= ST_RUN;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            wb_rd  <= mem_rd;
            wb_wr  <= mem_wr;
            mem_rd <= ex_rd;
            mem_wr <= ex_wr;
            if (action == ST_RUN) begin
                ex_rd <= bus.ID_rd;
                ex_wr <= bus.ID_RF_Enable && (bus.ID_rd != 5'd0);
                ex_ld <= bus.ID_Load_Instr;
            end else begin
                ex_rd <= 5'd0;
                ex_wr <= 1'b0;
                ex_ld <= 1'b0;
            end
            state <= action;
            if (action == ST_STALL && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
            if (action == ST_FLUSH && flush_cnt != '1)
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

    assign bus.Ctrl_State  = state;
    assign bus.Stall_Count = stall_cnt;
    assign bus.Flush_Count = flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with CNT_W=4: reset, forwarding priority, load-use,
// branch-over-stall, counter saturation and reset in the middle of a stall.
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W = 4;

    logic clk;
    logic Reset;
    int   total;
    int   bad;

    pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Drives one ID-stage instruction plus branch status, then lets the combinational outputs settle.
    task automatic applyStimulus(
        input logic [4:0] rs1, input logic [4:0] rs2,
        input logic u1, input logic u2,
        input logic [4:0] rd, input logic rfen, input logic ld, input logic br
    );
        bus.ID_rs1          = rs1;
        bus.ID_rs2          = rs2;
        bus.ID_rs1_used     = u1;
        bus.ID_rs2_used     = u2;
        bus.ID_rd           = rd;
        bus.ID_RF_Enable    = rfen;
        bus.ID_Load_Instr   = ld;
        bus.EX_Branch_Taken = br;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkRun(input string tag);
        checkOutput({tag, ".pc_le"}, int'(bus.PC_LE), 1);
        checkOutput({tag, ".ifid_le"}, int'(bus.IF_ID_LE), 1);
        checkOutput({tag, ".flush"}, int'(bus.IF_ID_Flush), 0);
        checkOutput({tag, ".bubble"}, int'(bus.ID_EX_Bubble), 0);
    endtask

    task automatic checkResetOut(input string tag);
        checkOutput({tag, ".pc_le"}, int'(bus.PC_LE), 0);
        checkOutput({tag, ".ifid_le"}, int'(bus.IF_ID_LE), 0);
        checkOutput({tag, ".flush"}, int'(bus.IF_ID_Flush), 1);
        checkOutput({tag, ".bubble"}, int'(bus.ID_EX_Bubble), 1);
        checkOutput({tag, ".fwd_a"}, int'(bus.Fwd_A), 0);
        checkOutput({tag, ".fwd_b"}, int'(bus.Fwd_B), 0);
    endtask

    initial begin
        total = 0;
        bad   = 0;

        // Reset with deliberately busy inputs
        Reset = 1'b1;
        applyStimulus(5'd5, 5'd5, 1, 1, 5'd5, 1, 1, 1);
        checkResetOut("rst_hold");
        tick();
        tick();
        checkResetOut("rst_hold2");
        checkOutput("rst.state", int'(bus.Ctrl_State), 0);
        checkOutput("rst.stall_cnt", int'(bus.Stall_Count), 0);
        checkOutput("rst.flush_cnt", int'(bus.Flush_Count), 0);

        Reset = 1'b0;
        applyStimulus(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0);
        checkRun("post_rst");

        // Forwarding priority: two writers of x5 then a reader
        applyStimulus(5'd0, 5'd0, 0, 0, 5'd5, 1, 0, 0);
        tick();
        applyStimulus(5'd0, 5'd0, 0, 0, 5'd5, 1, 0, 0);
        tick();
        applyStimulus(5'd5, 5'd5, 1, 1, 5'd7, 0, 0, 0);
        checkOutput("fwd_ex.a", int'(bus.Fwd_A), 1);
        checkOutput("fwd_ex.b", int'(bus.Fwd_B), 1);
        checkRun("fwd_ex");
        tick();
        checkOutput("fwd_mem.a", int'(bus.Fwd_A), 2);
        checkOutput("fwd_mem.b", int'(bus.Fwd_B), 2);
        tick();
        checkOutput("fwd_wb.a", int'(bus.Fwd_A), 3);
        checkOutput("fwd_wb.b", int'(bus.Fwd_B), 3);
        tick();
        checkOutput("fwd_rf.a", int'(bus.Fwd_A), 0);
        checkOutput("fwd_rf.b", int'(bus.Fwd_B), 0);

        // x0 reader with an x0 "writer" in EX
        applyStimulus(5'd0, 5'd0, 0, 0, 5'd0, 1, 0, 0);
        tick();
        applyStimulus(5'd0, 5'd0, 1, 1, 5'd8, 0, 0, 0);
        checkOutput("fwd_x0.a", int'(bus.Fwd_A), 0);
        checkOutput("fwd_x0.b", int'(bus.Fwd_B), 0);
        tick();

        // Load-use on rs2
        applyStimulus(5'd0, 5'd0, 0, 0, 5'd3, 1, 1, 0);
        tick();
        applyStimulus(5'd1, 5'd3, 1, 1, 5'd9, 1, 0, 0);
        checkOutput("lu.pc_le", int'(bus.PC_LE), 0);
        checkOutput("lu.ifid_le", int'(bus.IF_ID_LE), 0);
        checkOutput("lu.bubble", int'(bus.ID_EX_Bubble), 1);
        checkOutput("lu.flush", int'(bus.IF_ID_Flush), 0);
        checkOutput("lu.fwd_a", int'(bus.Fwd_A), 0);
        tick();
        checkRun("lu_after");
        checkOutput("lu_after.fwd_b", int'(bus.Fwd_B), 2);
        checkOutput("lu_after.state", int'(bus.Ctrl_State), 1);
        checkOutput("lu_after.stall_cnt", int'(bus.Stall_Count), 1);
        tick();
        checkOutput("lu_done.state", int'(bus.Ctrl_State), 0);

        // Branch in the same cycle as a load-use match
        applyStimulus(5'd0, 5'd0, 0, 0, 5'd4, 1, 1, 0);
        tick();
        applyStimulus(5'd4, 5'd0, 1, 0, 5'd10, 1, 0, 1);
        checkOutput("br.flush", int'(bus.IF_ID_Flush), 1);
        checkOutput("br.bubble", int'(bus.ID_EX_Bubble), 1);
        checkOutput("br.pc_le", int'(bus.PC_LE), 1);
        checkOutput("br.ifid_le", int'(bus.IF_ID_LE), 1);
        tick();
        checkOutput("br_after.state", int'(bus.Ctrl_State), 2);
        checkOutput("br_after.flush_cnt", int'(bus.Flush_Count), 1);
        checkOutput("br_after.stall_cnt", int'(bus.Stall_Count), 1);
        applyStimulus(5'd4, 5'd0, 1, 0, 5'd10, 1, 0, 0);
        checkRun("br_after");
        checkOutput("br_after.fwd_a", int'(bus.Fwd_A), 2);
        tick();

        // Back-to-back branches
        applyStimulus(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1);
        tick();
        checkOutput("bb.flush", int'(bus.IF_ID_Flush), 1);
        tick();
        checkOutput("bb.flush_cnt", int'(bus.Flush_Count), 3);
        checkOutput("bb.state", int'(bus.Ctrl_State), 2);

        // 17 further stall events; counter is already at 1 and must saturate at 15
        for (int i = 0; i < 17; i++) begin
            applyStimulus(5'd0, 5'd0, 0, 0, 5'd3, 1, 1, 0);
            tick();
            applyStimulus(5'd3, 5'd0, 1, 0, 5'd11, 1, 0, 0);
            checkOutput("sat.pc_le", int'(bus.PC_LE), 0);
            tick();
        end
        checkOutput("sat.stall_cnt", int'(bus.Stall_Count), 15);
        checkOutput("sat.flush_cnt", int'(bus.Flush_Count), 3);

        // Reset during a stall
        applyStimulus(5'd0, 5'd0, 0, 0, 5'd6, 1, 1, 0);
        tick();
        applyStimulus(5'd6, 5'd0, 1, 0, 5'd12, 1, 0, 0);
        checkOutput("rs_mid.stall", int'(bus.PC_LE), 0);
        Reset = 1'b1;
        #1;
        checkResetOut("rs_mid");
        tick();
        checkResetOut("rs_mid2");
        checkOutput("rs_mid.state", int'(bus.Ctrl_State), 0);
        checkOutput("rs_mid.stall_cnt", int'(bus.Stall_Count), 0);
        checkOutput("rs_mid.flush_cnt", int'(bus.Flush_Count), 0);
        Reset = 1'b0;
        applyStimulus(5'd6, 5'd0, 1, 0, 5'd12, 1, 0, 0);
        checkRun("rs_rel");
        checkOutput("rs_rel.fwd_a", int'(bus.Fwd_A), 0);
        tick();
        checkOutput("rs_rel.state", int'(bus.Ctrl_State), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
